soft_switches_bank: RTL and testbench

- Parametrised successor to the MCU soft-switch decoder.
- Takes the command word streamed from the MCU link: address in the upper field, data in the lower field.
- Holds NUM_REGS configuration registers of DATA_W bits each, with per-register reset defaults.
- Adds glitch filtering, self-clearing pulse registers (NMI/reset style), change strobes and a registered readback port.
- Sits between the MCU SPI receiver and the core (ROM bank, turbo, video, PSG, joystick and similar selects).

---
 rtl/soft_switches_pkg.sv | 31 +++
 rtl/soft_switches_pulse.sv | 34 +++
 rtl/soft_switches_bank.sv | 155 +++++++++++++++
 tb/tb_soft_switches_bank.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/soft_switches_pkg.sv
// Shared definitions for the soft-switch register bank: register map,
// settle FSM states and the default set of self-clearing registers.
package soft_switches_pkg;

  localparam int SW_ROM_BANK   = 0;
  localparam int SW_TURBOFDC   = 1;
  localparam int SW_COVOX      = 2;
  localparam int SW_PSG_MIX    = 3;
  localparam int SW_PSG_TYPE   = 4;
  localparam int SW_15KHZ      = 5;
  localparam int SW_60HZ       = 6;
  localparam int SW_TURBO      = 7;
  localparam int SW_SWAP_FDD   = 8;
  localparam int SW_JOY_TYPE   = 9;
  localparam int SW_VIDEO_MODE = 10;
  localparam int SW_DIVMMC     = 11;
  localparam int SW_NEMOIDE    = 12;
  localparam int SW_KBD_TYPE   = 13;
  localparam int SW_PAUSE      = 14;
  localparam int SW_NMI        = 15;
  localparam int SW_RESET      = 16;

  // NMI and reset are momentary: they fall back to their idle value on their own.
  localparam logic [31:0] DEFAULT_PULSE_MASK = (32'd1 << SW_NMI) | (32'd1 << SW_RESET);

  typedef enum logic {
    ST_IDLE,
    ST_SETTLE
  } state_t;

endpackage

// File: rtl/soft_switches_pulse.sv
// Hold timer for one self-clearing register: loaded on a commit, counts down
// every cycle and flags the edge on which the register must return to idle.
module soft_switches_pulse
  import soft_switches_pkg::*;
#(
  parameter int PULSE_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = (PULSE_LEN < 1) ? 1 : $clog2(PULSE_LEN + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(PULSE_LEN);
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A commit on the expiry edge reloads or clears instead, so it must win.
  assign expire = (cnt == CNT_W'(1)) && !load && !clear;

endmodule

// File: rtl/soft_switches_bank.sv
// Soft-switch register bank fed by the MCU command stream: debounces each
// command, commits it to the addressed register and exposes strobes/readback.
module soft_switches_bank
  import soft_switches_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int NUM_REGS      = 32,
  parameter int STABLE_CYCLES = 2,
  parameter int PULSE_LEN     = 4,
  parameter logic [NUM_REGS-1:0]        PULSE_MASK   = NUM_REGS'(DEFAULT_PULSE_MASK),
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALUES = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W+DATA_W-1:0]   softsw_command,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [NUM_REGS*DATA_W-1:0] sw_regs,
  output logic [NUM_REGS-1:0]        sw_changed,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       cmd_err,
  output logic                       busy
);

  localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [3:0]      STABLE_Q   = 4'(STABLE_CYCLES);

  state_t                   state, state_next;
  logic [ADDR_W+DATA_W-1:0] cmd_q, cmd_q_next;
  logic [3:0]               stable_cnt, stable_cnt_next;
  logic                     commit;
  logic [ADDR_W-1:0]        cmd_addr;
  logic [DATA_W-1:0]        cmd_data;
  logic                     addr_ok;
  logic [DATA_W-1:0]        rd_next;

  assign cmd_addr = cmd_q[ADDR_W+DATA_W-1 -: ADDR_W];
  assign cmd_data = cmd_q[DATA_W-1:0];
  assign addr_ok  = {1'b0, cmd_addr} < NUM_REGS_A;
  assign busy     = (state == ST_SETTLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cmd_q      <= '0;
      stable_cnt <= '0;
    end else begin
      state      <= state_next;
      cmd_q      <= cmd_q_next;
      stable_cnt <= stable_cnt_next;
    end
  end

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves one unassigned; a missed default would infer a latch.
  always_comb begin
    state_next      = state;
    cmd_q_next      = cmd_q;
    stable_cnt_next = stable_cnt;
    commit          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (softsw_command != cmd_q) begin
          cmd_q_next      = softsw_command;
          stable_cnt_next = '0;
          state_next      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (softsw_command != cmd_q) begin
          cmd_q_next      = softsw_command;
          stable_cnt_next = '0;
        end else if (stable_cnt >= STABLE_Q) begin
          commit     = 1'b1;
          state_next = ST_IDLE;
        end else if (stable_cnt != 4'hF) begin
          stable_cnt_next = stable_cnt + 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [DATA_W-1:0] RST_VAL = RESET_VALUES[i*DATA_W +: DATA_W];

    logic              hit;
    logic              expire;
    logic              changed;
    logic [DATA_W-1:0] value, value_next;

    assign hit = commit && addr_ok && (cmd_addr == ADDR_W'(i));

    if (PULSE_MASK[i]) begin : g_pulse
      soft_switches_pulse #(
        .PULSE_LEN(PULSE_LEN)
      ) u_pulse (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (hit && (cmd_data != RST_VAL)),
        .clear (hit && (cmd_data == RST_VAL)),
        .expire(expire)
      );
    end else begin : g_hold
      assign expire = 1'b0;
    end

    // NOTE: combinational next-value logic uses blocking '=', the flops below
    // use non-blocking '<=' so all registers sample the same pre-edge state.
    always_comb begin
      value_next = value;
      if (hit) begin
        value_next = cmd_data;
      end else if (expire) begin
        value_next = RST_VAL;
      end
    end

    // NOTE: these are individual flops with their own idle values, not a RAM,
    // so they are reset like any other control state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        value   <= RST_VAL;
        changed <= 1'b0;
      end else begin
        value   <= value_next;
        changed <= (value_next != value);
      end
    end

    assign sw_regs[i*DATA_W +: DATA_W] = value;
    assign sw_changed[i]               = changed;
  end

  // Out-of-range addresses match no entry and read back as zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_next = sw_regs[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      cmd_err <= 1'b0;
    end else begin
      rd_data <= rd_next;
      cmd_err <= commit && !addr_ok;
    end
  end

endmodule

// File: tb/tb_soft_switches_bank.sv
// Self-checking bench for soft_switches_bank: directed scenarios plus random
// command streams compared against a behavioural model every cycle.
module tb_soft_switches_bank;

  localparam int          NREGS  = 32;
  localparam int          STABLE = 2;
  localparam int          PLEN   = 4;
  localparam logic [31:0] PMASK  = 32'h0001_8000;

  logic                 clk;
  logic                 rst_n;
  logic [15:0]          softsw_command;
  logic [7:0]           rd_addr;
  logic [NREGS*8-1:0]   sw_regs;
  logic [NREGS-1:0]     sw_changed;
  logic [7:0]           rd_data;
  logic                 cmd_err;
  logic                 busy;

  soft_switches_bank dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .softsw_command(softsw_command),
    .rd_addr       (rd_addr),
    .sw_regs       (sw_regs),
    .sw_changed    (sw_changed),
    .rd_data       (rd_data),
    .cmd_err       (cmd_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [7:0]       m_regs [NREGS];
  int               m_left [NREGS];
  logic [NREGS-1:0] m_changed;
  logic             m_err;
  logic [7:0]       m_rd;
  logic [15:0]      m_last;
  int               m_run;
  bit               m_settling;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = 8'h00;
      m_left[i] = 0;
    end
    m_changed  = '0;
    m_err      = 1'b0;
    m_rd       = 8'h00;
    m_last     = 16'h0000;
    m_run      = 0;
    m_settling = 0;
  endtask

  // Advances the model by one clock edge using the inputs present before it.
  task automatic model_edge(input logic [15:0] cmd, input logic [7:0] ra);
    logic [7:0] nxt [NREGS];
    int addr;
    m_rd  = (ra < NREGS) ? m_regs[ra] : 8'h00;
    m_err = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      nxt[i] = m_regs[i];
      if (m_left[i] > 0) begin
        m_left[i]--;
        if (m_left[i] == 0) nxt[i] = 8'h00;
      end
    end
    if (cmd != m_last) begin
      m_last     = cmd;
      m_run      = 0;
      m_settling = 1;
    end else if (m_settling) begin
      if (m_run >= STABLE) begin
        m_settling = 0;
        addr = int'(m_last[15:8]);
        if (addr >= NREGS) begin
          m_err = 1'b1;
        end else begin
          nxt[addr] = m_last[7:0];
          if (PMASK[addr]) m_left[addr] = (m_last[7:0] != 8'h00) ? PLEN : 0;
        end
      end else begin
        m_run++;
      end
    end
    for (int i = 0; i < NREGS; i++) begin
      m_changed[i] = (nxt[i] != m_regs[i]);
      m_regs[i]    = nxt[i];
    end
  endtask

  task automatic check_all(input string tag);
    logic [NREGS*8-1:0] exp_flat;
    for (int i = 0; i < NREGS; i++) exp_flat[i*8 +: 8] = m_regs[i];
    check({tag, ".regs"},    256'(sw_regs),    256'(exp_flat));
    check({tag, ".changed"}, 256'(sw_changed), 256'(m_changed));
    check({tag, ".err"},     256'(cmd_err),    256'(m_err));
    check({tag, ".busy"},    256'(busy),       256'(m_settling));
    check({tag, ".rd"},      256'(rd_data),    256'(m_rd));
  endtask

  task automatic step(input string tag, input logic [15:0] cmd, input logic [7:0] ra);
    softsw_command = cmd;
    rd_addr        = ra;
    model_edge(cmd, ra);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic hold(input string tag, input logic [15:0] cmd, input logic [7:0] ra, input int n);
    for (int k = 0; k < n; k++) step(tag, cmd, ra);
  endtask

  // Async reset applied between clock edges; checked while still asserted.
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    softsw_command = 16'h0000;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    softsw_command = 16'h0000;
    rd_addr        = 8'h00;
    model_reset();
    #3;
    check_all("reset");
    rst_n = 1'b1;

    hold("idle_zero", 16'h0000, 8'h00, 4);

    // Basic commit: busy for edges 0..2, value lands at edge 3
    step("w7_e0", 16'h0702, 8'h07);
    check("w7_busy_e0", 256'(busy), 256'(1'b1));
    step("w7_e1", 16'h0702, 8'h07);
    step("w7_e2", 16'h0702, 8'h07);
    check("w7_pre", 256'(sw_regs[63:56]), 256'(8'h00));
    step("w7_e3", 16'h0702, 8'h07);
    check("w7_val", 256'(sw_regs[63:56]), 256'(8'h02));
    check("w7_strobe", 256'(sw_changed), 256'(32'h0000_0080));
    step("w7_e4", 16'h0702, 8'h07);
    check("w7_rd", 256'(rd_data), 256'(8'h02));
    hold("w7_idle", 16'h0702, 8'h07, 2);

    // Glitch rejection
    step("glitch", 16'h0A01, 8'h0A);
    hold("glitch_settle", 16'h0A03, 8'h0A, 5);
    check("glitch_val", 256'(sw_regs[87:80]), 256'(8'h03));

    // Pulse register: set, expire, retrigger
    hold("pulse16", 16'h1001, 8'h10, 9);
    check("pulse16_expired", 256'(sw_regs[135:128]), 256'(8'h00));
    hold("pulse16_zero", 16'h1000, 8'h10, 4);
    hold("pulse16_again", 16'h1001, 8'h10, 5);

    // Retrigger on reg15, commit on the expiry edge, then early clear
    hold("nmi_a", 16'h0F01, 8'h0F, 4);
    hold("nmi_b", 16'h0F02, 8'h0F, 4);
    hold("nmi_c", 16'h0F03, 8'h0F, 3);
    hold("nmi_clr", 16'h0F00, 8'h0F, 6);

    // Out-of-range address
    hold("oor", 16'h2055, 8'h20, 5);

    // Reset mid-settle and mid-pulse
    hold("rst_settle", 16'h0533, 8'h05, 2);
    mid_reset("rst_mid_settle");
    hold("post_rst", 16'h0000, 8'h05, 3);
    hold("rst_pulse", 16'h1002, 8'h10, 4);
    mid_reset("rst_mid_pulse");
    hold("post_rst2", 16'h0000, 8'h10, 3);

    // Random command streams
    for (int t = 0; t < 60; t++) begin
      int sel;
      logic [7:0] a;
      logic [7:0] d;
      sel = int'($urandom_range(0, 9));
      if (sel < 3)       a = (sel == 0) ? 8'd15 : 8'd16;
      else if (sel == 3) a = 8'($urandom_range(32, 40));
      else               a = 8'($urandom_range(0, 31));
      d = 8'($urandom_range(0, 3));
      hold("rand", {a, d}, 8'($urandom_range(0, 35)), int'($urandom_range(1, 6)));
    end
    hold("tail", 16'h0000, 8'h00, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
